// File: rtl/ula_sched_pkg.sv
// Shared types and constants for the ALU request scheduler.
package ula_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FLAG_O = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_Z = 0;

  localparam logic [1:0] FMT_FLAG = 2'b10;

  // Arith/logic op codes carried in op[4:0]; op[5] swaps the operands.
  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4;
  localparam logic [4:0] OP_NOT = 5'd5;

  function automatic logic is_flag_op(input logic [7:0] op);
    return op[7:6] == FMT_FLAG;
  endfunction

endpackage

// File: rtl/ula_sched_if.sv
// Request/response bundle between two requesters, the scheduler and its consumer.
interface ula_sched_if #(parameter int bits = 16);
  logic            req0_valid, req0_ready;
  logic [bits-1:0] req0_a, req0_b;
  logic [7:0]      req0_op;
  logic            req1_valid, req1_ready;
  logic [bits-1:0] req1_a, req1_b;
  logic [7:0]      req1_op;
  logic            rsp_valid, rsp_ready, rsp_id;
  logic [bits-1:0] rsp_resu;
  logic [3:0]      rsp_flags, flag_reg;
  logic            busy;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_resu, rsp_flags, flag_reg, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_resu, rsp_flags, flag_reg, busy
  );
endinterface

// File: rtl/ula_rr_arb.sv
// Two-way round-robin grant; last_grant advances only when the grant is taken.
module ula_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic       grant
);

  logic last_grant;

  // Contention goes to whoever did not win last; otherwise the lone requester.
  always_comb grant = (valid[0] && valid[1]) ? ~last_grant : valid[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_grant <= 1'b1;
    else if (accept) last_grant <= grant;
  end

endmodule

// File: rtl/ula_sched_alu.sv
// Combinational ALU: add/sub/logic with {O,C,S,Z}; C is carry on add, borrow on sub.
module ula_sched_alu import ula_sched_pkg::*; #(parameter int bits = 16) (
  input  logic [bits-1:0] a,
  input  logic [bits-1:0] b,
  input  logic [5:0]      op,
  output logic [bits-1:0] resu,
  output logic [3:0]      flags
);

  logic [bits-1:0] x, y;
  logic [bits:0]   wide;
  logic            o, c;

  always_comb begin
    x    = op[5] ? b : a;
    y    = op[5] ? a : b;
    wide = '0;
    o    = 1'b0;
    c    = 1'b0;
    resu = x;
    case (op[4:0])
      OP_ADD: begin
        wide = {1'b0, x} + {1'b0, y};
        resu = wide[bits-1:0];
        c    = wide[bits];
        o    = (x[bits-1] == y[bits-1]) && (resu[bits-1] != x[bits-1]);
      end
      OP_SUB: begin
        wide = {1'b0, x} - {1'b0, y};
        resu = wide[bits-1:0];
        c    = wide[bits];
        o    = (x[bits-1] != y[bits-1]) && (resu[bits-1] != x[bits-1]);
      end
      OP_AND:  resu = x & y;
      OP_OR:   resu = x | y;
      OP_XOR:  resu = x ^ y;
      OP_NOT:  resu = ~x;
      default: resu = x;
    endcase
    flags         = '0;
    flags[FLAG_O] = o;
    flags[FLAG_C] = c;
    flags[FLAG_S] = resu[bits-1];
    flags[FLAG_Z] = (resu == '0);
  end

endmodule

// File: rtl/ula_sched.sv
// Two-requester ALU scheduler: round-robin accept, one EXEC cycle, held response.
module ula_sched import ula_sched_pkg::*; #(parameter int bits = 16) (
  input logic        clk,
  input logic        rst,
  ula_sched_if.slave bus
);

  state_t          state_q, state_d;
  logic            grant, accept;
  logic [bits-1:0] a_q, b_q, alu_resu, resu_q;
  logic [7:0]      op_q;
  logic            id_q, rsp_id_q;
  logic [3:0]      alu_flags, rsp_flags_q, flag_reg_q;

  ula_rr_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  ({bus.req1_valid, bus.req0_valid}),
    .accept (accept),
    .grant  (grant)
  );

  ula_sched_alu #(.bits(bits)) ULA (
    .a     (a_q),
    .b     (b_q),
    .op    (op_q[5:0]),
    .resu  (alu_resu),
    .flags (alu_flags)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req0_ready = !grant && bus.req0_valid;
        bus.req1_ready =  grant && bus.req1_valid;
        if (bus.req0_ready || bus.req1_ready) state_d = EXEC;
      end
      EXEC:    state_d = DONE;
      DONE:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign accept = bus.req0_ready || bus.req1_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      id_q        <= 1'b0;
      resu_q      <= '0;
      rsp_id_q    <= 1'b0;
      rsp_flags_q <= '0;
      flag_reg_q  <= '0;
    end else begin
      if (accept) begin
        a_q  <= grant ? bus.req1_a  : bus.req0_a;
        b_q  <= grant ? bus.req1_b  : bus.req0_b;
        op_q <= grant ? bus.req1_op : bus.req0_op;
        id_q <= grant;
      end
      // Constant-format ops report zero flags and leave the sticky register alone.
      if (state_q == EXEC) begin
        resu_q      <= alu_resu;
        rsp_id_q    <= id_q;
        rsp_flags_q <= is_flag_op(op_q) ? alu_flags : 4'b0000;
        if (is_flag_op(op_q)) flag_reg_q <= alu_flags;
      end
    end
  end

  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_resu  = resu_q;
  assign bus.rsp_flags = rsp_flags_q;
  assign bus.flag_reg  = flag_reg_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ula_sched.sv
// Directed + randomized bench for ula_sched against a transaction-level reference model.
module tb_ula_sched;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ula_sched_if #(.bits(W)) bus();

  ula_sched #(.bits(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int exp_last = 1;
  logic [3:0] exp_flag_reg = 4'b0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Integer-arithmetic model of the ALU; flags {O,C,S,Z} before format gating.
  function automatic void ref_alu(input logic [W-1:0] a, b, input logic [7:0] op,
                                  output logic [W-1:0] r, output logic [3:0] f);
    int x, y, sx, sy, s;
    if (op[5]) begin x = int'(b); y = int'(a); end
    else       begin x = int'(a); y = int'(b); end
    sx = (x >= 32768) ? x - 65536 : x;
    sy = (y >= 32768) ? y - 65536 : y;
    f = 4'b0000;
    case (op[4:0])
      5'd0: begin r = 16'(x + y); s = sx + sy; f[2] = (x + y) > 65535; f[3] = (s > 32767) || (s < -32768); end
      5'd1: begin r = 16'(x - y); s = sx - sy; f[2] = (x < y);         f[3] = (s > 32767) || (s < -32768); end
      5'd2: r = 16'(x & y);
      5'd3: r = 16'(x | y);
      5'd4: r = 16'(x ^ y);
      5'd5: r = 16'(~x);
      default: r = 16'(x);
    endcase
    f[1] = r[15];
    f[0] = (r == 16'h0000);
  endfunction

  // One full transaction starting from an IDLE cycle; bp = cycles of held backpressure in DONE.
  task automatic txn(input bit v0, v1, input logic [W-1:0] a0, b0, a1, b1,
                     input logic [7:0] op0, op1, input int bp, input bit noise);
    int win;
    logic [W-1:0] er;
    logic [3:0] ef, erf;
    logic [7:0] wop;
    chk("idle_busy", bus.busy, 0);
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_op = op0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_op = op1;
    #1;
    win = (v0 && v1) ? 1 - exp_last : (v1 ? 1 : 0);
    chk("accept_ready0", bus.req0_ready, 32'(v0 && win == 0));
    chk("accept_ready1", bus.req1_ready, 32'(v1 && win == 1));
    if (win == 0) begin ref_alu(a0, b0, op0, er, ef); wop = op0; end
    else          begin ref_alu(a1, b1, op1, er, ef); wop = op1; end
    exp_last = win;
    erf = (wop[7:6] == 2'b10) ? ef : 4'b0000;
    @(posedge clk); #1;
    if (noise) bus.rsp_ready = 1'($urandom_range(0, 1));
    chk("exec_busy", bus.busy, 1);
    chk("exec_rsp_valid", bus.rsp_valid, 0);
    chk("exec_readies", {bus.req1_ready, bus.req0_ready}, 0);
    @(posedge clk); #1;
    if (wop[7:6] == 2'b10) exp_flag_reg = ef;
    chk("done_rsp_valid", bus.rsp_valid, 1);
    chk("done_rsp_id", bus.rsp_id, 32'(win));
    chk("done_rsp_resu", bus.rsp_resu, 32'(er));
    chk("done_rsp_flags", bus.rsp_flags, 32'(erf));
    chk("done_flag_reg", bus.flag_reg, 32'(exp_flag_reg));
    for (int i = 0; i < bp; i++) begin
      bus.rsp_ready = 1'b0;
      if (noise) begin
        bus.req0_valid = 1'($urandom_range(0, 1));
        bus.req1_valid = 1'($urandom_range(0, 1));
      end else begin
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
      end
      @(posedge clk); #1;
      chk("bp_rsp_valid", bus.rsp_valid, 1);
      chk("bp_busy", bus.busy, 1);
      chk("bp_readies", {bus.req1_ready, bus.req0_ready}, 0);
      chk("bp_rsp_resu", bus.rsp_resu, 32'(er));
      chk("bp_rsp_flags", bus.rsp_flags, 32'(erf));
      chk("bp_rsp_id", bus.rsp_id, 32'(win));
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("release_rsp_valid", bus.rsp_valid, 0);
    chk("release_busy", bus.busy, 0);
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'hFFFF;
      3: return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [7:0] rnd_op();
    return {2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7))};
  endfunction

  initial begin
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
    bus.rsp_ready  = 1'b0;

    // Reset state
    #2 rst = 1'b1;
    #2;
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_rsp_resu", bus.rsp_resu, 0);
    chk("rst_rsp_flags", bus.rsp_flags, 0);
    chk("rst_flag_reg", bus.flag_reg, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Single add, flags enabled: 5 + 3
    txn(1, 0, 16'd5, 16'd3, 16'd0, 16'd0, 8'h80, 8'h00, 0, 0);
    // Signed overflow: 7FFF + 1 -> O and S set
    txn(1, 0, 16'h7FFF, 16'd1, 16'd0, 16'd0, 8'h80, 8'h00, 0, 0);
    chk("ovf_flag_reg", bus.flag_reg, 32'h0000_000A);
    // Constant-format op keeps flag_reg
    txn(1, 0, 16'hFFFF, 16'd1, 16'd0, 16'd0, 8'h00, 8'h00, 0, 0);
    chk("const_flag_reg", bus.flag_reg, 32'h0000_000A);
    // Backpressure for 5 cycles with both requesters pending
    txn(0, 1, 16'd0, 16'd0, 16'h8000, 16'd1, 8'h00, 8'h81, 5, 0);

    // Reset during EXEC discards the transaction
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b0;
    bus.req0_a = 16'd9; bus.req0_b = 16'd9; bus.req0_op = 8'h81;
    #1;
    @(posedge clk); #1;
    chk("pre_rst_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_flag_reg", bus.flag_reg, 0);
    bus.req0_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
    end
    @(negedge clk) rst = 1'b0;
    exp_last = 1;
    exp_flag_reg = 4'b0000;
    @(posedge clk); #1;
    chk("post_rst_rsp_valid", bus.rsp_valid, 0);

    // Contention: both valid for 4 ops, grants alternate starting with req0
    for (int i = 0; i < 4; i++)
      txn(1, 1, 16'(10 + i), 16'd1, 16'(100 + i), 16'd2, 8'h80, 8'h81, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      bit v0, v1;
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      txn(v0, v1, rnd_val(), rnd_val(), rnd_val(), rnd_val(), rnd_op(), rnd_op(),
          int'($urandom_range(0, 3)), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
